// File: rtl/pmod_dac_pkg.sv
// Shared definitions for the Pmod serial DAC driver: FSM state encoding,
// DAC121S101 power-down codes and the frame-word builder.
package pmod_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        QUIET = 2'd2
    } state_t;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    // Frame word is {zero pad, pd, data}; data must already be zero-extended
    // above data_w. Callers truncate the result to their frame width (<= 32).
    function automatic logic [31:0] build_frame(input logic [1:0]  pd,
                                                input logic [31:0] data,
                                                input int          data_w);
        return ({30'd0, pd} << data_w) | data;
    endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK divider for the DAC driver. Counts CLK_DIV clk cycles per SCLK
// half-period while enabled; clr (or rst) parks SCLK high with the counter
// at zero. rise/fall flag the edge on which SCLK toggles 0->1 / 1->0.
module dac_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = en && (cnt_q == CNT_LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    // Half-period counter and SCLK toggle; SCLK idles high.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
            sclk  <= 1'b1;
        end else if (en) begin
            if (wrap) begin
                cnt_q <= '0;
                sclk  <= ~sclk;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pmod_dac_serializer.sv
// N-channel serial driver for DAC121S101-style converters (Pmod DA2 and
// wider boards). One word per channel is latched on update/ready and shifted
// MSB-first on its own SDATA line under a shared SYNC/SCLK.
// Handshake: a word set is accepted on a clk edge where update=1 and ready=1;
// update while ready=0 is dropped (no queue).
// Optional build macro PMOD_DAC_CONTINUOUS_EN: after each frame's quiet time
// the last latched words are re-sent automatically unless update supplies
// new ones in the single ready cycle.
module pmod_dac_serializer
    import pmod_dac_pkg::*;
#(
    parameter int         NUM_CH    = 2,
    parameter int         DATA_W    = 12,
    parameter int         FRAME_W   = 16,
    parameter int         CLK_DIV   = 2,
    parameter int         QUIET_CYC = 4,
    parameter logic [1:0] PD_MODE   = PD_NORMAL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     update,
    input  logic [NUM_CH*DATA_W-1:0] values,
    output logic                     ready,
    output logic                     done,
    output logic [NUM_CH-1:0]        SDATA,
    output logic                     SYNC,
    output logic                     SCLK,
    output state_t                   state_dbg
);

    localparam int BW = $clog2(FRAME_W + 1);
    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_W);
    // The done/ready cycle is itself the last quiet cycle, so QUIET proper
    // lasts QUIET_CYC-1 cycles after the cycle SYNC rises.
    localparam logic [QW-1:0] QUIET_LAST = QW'((QUIET_CYC >= 2) ? QUIET_CYC - 2 : 0);

    state_t state_q, state_n;
    logic   sync_q, sync_n;
    logic   ready_q, ready_n;
    logic   done_q, done_n;
    logic   load, take_new;

    logic [BW-1:0]              bitcnt_q;
    logic [QW-1:0]              qcnt_q;
    logic [NUM_CH*DATA_W-1:0]   lat_q;
    logic [NUM_CH*DATA_W-1:0]   src;
    logic                       sclk_rise, sclk_fall, last_rise;

`ifdef PMOD_DAC_CONTINUOUS_EN
    logic have_data_q;
`endif

    dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == SHIFT),
        .clr  (state_q != SHIFT),
        .sclk (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Rising toggle after the last falling edge closes the frame.
    assign last_rise = sclk_rise && (bitcnt_q == FRAME_LAST);
    assign src       = take_new ? values : lat_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_n  = state_q;
        sync_n   = sync_q;
        ready_n  = ready_q;
        done_n   = 1'b0;
        load     = 1'b0;
        take_new = 1'b0;
        case (state_q)
            IDLE: begin
                if (update) begin
                    load     = 1'b1;
                    take_new = 1'b1;
                end
`ifdef PMOD_DAC_CONTINUOUS_EN
                else if (have_data_q) begin
                    load = 1'b1;
                end
`endif
                if (load) begin
                    state_n = SHIFT;
                    sync_n  = 1'b0;
                    ready_n = 1'b0;
                end
            end
            SHIFT: begin
                if (last_rise) begin
                    sync_n = 1'b1;
                    if (QUIET_CYC < 2) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        ready_n = 1'b1;
                    end else begin
                        state_n = QUIET;
                    end
                end
            end
            QUIET: begin
                if (qcnt_q == QUIET_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                sync_n  = 1'b1;
                ready_n = 1'b1;
            end
        endcase
    end

    // FSM state and control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            sync_q  <= sync_n;
            ready_q <= ready_n;
            done_q  <= done_n;
        end
    end

    // Bit counter (falling edges), quiet counter and word latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt_q <= '0;
            qcnt_q   <= '0;
            lat_q    <= '0;
        end else begin
            if (load)
                bitcnt_q <= '0;
            else if (sclk_fall)
                bitcnt_q <= bitcnt_q + BW'(1);
            if (state_q == QUIET)
                qcnt_q <= qcnt_q + QW'(1);
            else
                qcnt_q <= '0;
            if (take_new)
                lat_q <= values;
        end
    end

`ifdef PMOD_DAC_CONTINUOUS_EN
    // Auto-repeat is armed only once real data has been latched.
    always_ff @(posedge clk) begin
        if (rst)
            have_data_q <= 1'b0;
        else if (take_new)
            have_data_q <= 1'b1;
    end
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [FRAME_W-1:0] frame;
        logic [FRAME_W-1:0] sreg_q;
        logic               sd_q;

        assign frame = FRAME_W'(build_frame(PD_MODE, 32'(src[k*DATA_W +: DATA_W]), DATA_W));

        // Per-lane shifter: MSB on load, next bit on each SCLK rise, 0 at frame end.
        always_ff @(posedge clk) begin
            if (rst) begin
                sreg_q <= '0;
                sd_q   <= 1'b0;
            end else if (load) begin
                sd_q   <= frame[FRAME_W-1];
                sreg_q <= {frame[FRAME_W-2:0], 1'b0};
            end else if (sclk_rise) begin
                if (last_rise) begin
                    sd_q <= 1'b0;
                end else begin
                    sd_q   <= sreg_q[FRAME_W-1];
                    sreg_q <= {sreg_q[FRAME_W-2:0], 1'b0};
                end
            end
        end

        assign SDATA[k] = sd_q;
    end

    assign SYNC      = sync_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pmod_dac_serializer.sv
// Bench for pmod_dac_serializer: a default 2-channel instance (a) and a
// 4-channel, CLK_DIV=3, PD=11 instance (b). Frames are reassembled from
// SDATA at SCLK falling edges and scored against expected words queued by
// the stimulus. Build with PMOD_DAC_CONTINUOUS_EN for the auto-repeat run.
module tb_pmod_dac_serializer;
    import pmod_dac_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, update_a, ready_a, done_a, sync_a, sclk_a;
    logic [23:0] values_a;
    logic [1:0]  sdata_a;
    state_t      st_a;

    logic        rst_b, update_b, ready_b, done_b, sync_b, sclk_b;
    logic [47:0] values_b;
    logic [3:0]  sdata_b;
    state_t      st_b;

    pmod_dac_serializer dut_a (
        .clk(clk), .rst(rst_a), .update(update_a), .values(values_a),
        .ready(ready_a), .done(done_a), .SDATA(sdata_a), .SYNC(sync_a),
        .SCLK(sclk_a), .state_dbg(st_a)
    );

    pmod_dac_serializer #(
        .NUM_CH(4), .DATA_W(12), .FRAME_W(16), .CLK_DIV(3), .QUIET_CYC(4),
        .PD_MODE(2'b11)
    ) dut_b (
        .clk(clk), .rst(rst_b), .update(update_b), .values(values_b),
        .ready(ready_b), .done(done_b), .SDATA(sdata_b), .SYNC(sync_b),
        .SCLK(sclk_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- monitor a ----------------
    bit          a_in = 0, a_wait_done = 0, a_prev_sclk = 1;
    int          a_len = 0, a_falls = 0, a_high = 0, a_last_gap = 0;
    int          a_frames = 0, a_dones = 0;
    logic [15:0] a_cap0 = '0, a_cap1 = '0;

    always @(negedge clk) begin
        if (rst_a) begin
            a_in = 0; a_wait_done = 0; a_prev_sclk = 1; a_high = 0;
        end else begin
            if (!sync_a) begin
                if (!a_in) begin
                    a_in = 1; a_len = 0; a_falls = 0; a_cap0 = '0; a_cap1 = '0;
                    a_last_gap = a_high;
                end
                a_len++;
                if (a_prev_sclk && !sclk_a) begin
                    a_falls++;
                    a_cap0 = {a_cap0[14:0], sdata_a[0]};
                    a_cap1 = {a_cap1[14:0], sdata_a[1]};
                end
            end else begin
                if (a_in) begin
                    a_in = 0; a_frames++; a_high = 0;
                    check("a_prev_done_seen", a_wait_done, 0);
                    a_wait_done = 1;
                    check("a_sync_low_len", a_len, 64);
                    check("a_fall_count", a_falls, 16);
                    if (exp_a_q.size() == 0)
                        fail("a_unexpected_frame");
                    else
                        check("a_frame", {a_cap1, a_cap0}, exp_a_q.pop_front());
                end
                a_high++;
            end
            if (done_a) begin
                a_dones++;
                check("a_done_after_frame", a_wait_done, 1);
                check("a_done_gap", a_high, 4);
                a_wait_done = 0;
            end
            a_prev_sclk = sclk_a;
        end
    end

    // ---------------- monitor b ----------------
    bit          b_in = 0, b_prev_sclk = 1;
    int          b_len = 0, b_falls = 0, b_frames = 0;
    logic [15:0] b_cap[4];

    always @(negedge clk) begin
        if (rst_b) begin
            b_in = 0; b_prev_sclk = 1;
        end else begin
            if (!sync_b) begin
                if (!b_in) begin
                    b_in = 1; b_len = 0; b_falls = 0;
                    for (int i = 0; i < 4; i++) b_cap[i] = '0;
                end
                b_len++;
                if (b_prev_sclk && !sclk_b) begin
                    b_falls++;
                    for (int i = 0; i < 4; i++) b_cap[i] = {b_cap[i][14:0], sdata_b[i]};
                end
            end else if (b_in) begin
                b_in = 0; b_frames++;
                check("b_sync_low_len", b_len, 96);
                check("b_fall_count", b_falls, 16);
                if (exp_b_q.size() == 0)
                    fail("b_unexpected_frame");
                else
                    check("b_frame", {b_cap[3], b_cap[2], b_cap[1], b_cap[0]}, exp_b_q.pop_front());
            end
            b_prev_sclk = sclk_b;
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end 1 time unit after a rising edge.
    task automatic pulse_a(input logic [23:0] v);
        values_a = v; update_a = 1'b1;
        @(posedge clk); #1;
        update_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [47:0] v);
        values_b = v; update_b = 1'b1;
        @(posedge clk); #1;
        update_b = 1'b0;
    endtask

    // Returns at the falling edge inside the done cycle.
    task automatic wait_done_a(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        if (!seen) fail("a_done_timeout");
    endtask

    task automatic wait_done_b(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done_b) seen = 1;
        end
        if (!seen) fail("b_done_timeout");
    endtask

    task automatic align;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int saved;
        rst_a = 1'b1; update_a = 1'b0; values_a = '0;
        rst_b = 1'b1; update_b = 1'b0; values_b = '0;
        idle(3);
        check("a_rst_sync", sync_a, 1);
        check("a_rst_sclk", sclk_a, 1);
        check("a_rst_sdata", sdata_a, 0);
        check("a_rst_ready", ready_a, 1);
        check("a_rst_done", done_a, 0);
        check("a_rst_state", st_a, IDLE);
        check("b_rst_sdata", sdata_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        idle(2);

`ifndef PMOD_DAC_CONTINUOUS_EN
        // Basic frame.
        exp_a_q.push_back(32'h0FFF_0AAA);
        pulse_a({12'hFFF, 12'hAAA});
        check("a_accept_sync", sync_a, 0);
        check("a_accept_ready", ready_a, 0);
        check("a_accept_sclk", sclk_a, 1);
        wait_done_a(200);
        check("a_done_cycle_ready", ready_a, 1);
        align;

        // Busy ignore: second update mid-frame must be dropped.
        exp_a_q.push_back(32'h0FFF_0AAA);
        pulse_a({12'hFFF, 12'hAAA});
        idle(9);
        pulse_a({12'hFFF, 12'h123});
        check("a_busy_ready", ready_a, 0);
        idle(30);
        check("a_busy_ready_late", ready_a, 0);
        wait_done_a(200);
        align;
        idle(100);
        check("a_idle_after_busy", sync_a, 1);

        // Held update: back-to-back frames, released in the third done cycle.
        values_a = {12'h000, 12'h001};
        update_a = 1'b1;
        repeat (3) exp_a_q.push_back(32'h0000_0001);
        wait_done_a(200);
        wait_done_a(200);
        wait_done_a(200);
        update_a = 1'b0;
        align;
        check("a_held_gap", a_last_gap, 4);
        idle(100);

        // Reset after the 7th falling edge: frame discarded, no done.
        pulse_a({12'h3C3, 12'h5A5});
        begin
            bit hit = 0;
            for (int n = 0; n < 100 && !hit; n++) begin
                @(posedge clk);
                if (a_falls == 7 && a_in) hit = 1;
            end
            if (!hit) fail("a_seventh_fall_timeout");
        end
        #1 rst_a = 1'b1;
        align;
        rst_a = 1'b0;
        check("a_abort_sync", sync_a, 1);
        check("a_abort_sclk", sclk_a, 1);
        check("a_abort_ready", ready_a, 1);
        saved = a_dones;
        idle(20);
        check("a_abort_no_done", a_dones, saved);
        exp_a_q.push_back(32'h03C3_05A5);
        pulse_a({12'h3C3, 12'h5A5});
        wait_done_a(200);
        align;

        // Simultaneous reset and update: reset wins, nothing latched.
        values_a = {12'h111, 12'h222};
        rst_a = 1'b1; update_a = 1'b1;
        align;
        rst_a = 1'b0; update_a = 1'b0;
        check("a_rst_upd_ready", ready_a, 1);
        check("a_rst_upd_sync", sync_a, 1);
        idle(80);
`else
        // Continuous mode: nothing is sent before the first update.
        idle(50);
        check("a_cont_idle_frames", a_frames, 0);
        repeat (2) exp_a_q.push_back(32'h0000_0555);
        pulse_a({12'h000, 12'h555});
        wait_done_a(200);
        wait_done_a(200);
        check("a_cont_boundary_ready", ready_a, 1);
        values_a = {12'h000, 12'h0F0};
        update_a = 1'b1;
        repeat (2) exp_a_q.push_back(32'h0000_00F0);
        align;
        update_a = 1'b0;
        check("a_cont_ready_dropped", ready_a, 0);
        wait_done_a(200);
        wait_done_a(200);
        align;
        idle(5);
        rst_a = 1'b1;
        align;
        rst_a = 1'b0;
        idle(80);
        check("a_cont_done_count", a_dones, 4);
`endif

        // Wide instance: 4 lanes, PD=11, CLK_DIV=3.
        exp_b_q.push_back(64'h3800_3400_3001_3FFF);
        pulse_b({12'h800, 12'h400, 12'h001, 12'hFFF});
        wait_done_b(300);
        values_b = {12'h123, 12'hABC, 12'h000, 12'h7FF};
        update_b = 1'b1;
        exp_b_q.push_back(64'h3123_3ABC_3000_37FF);
        align;
        update_b = 1'b0;
        wait_done_b(300);
        align;
        idle(3);
        rst_b = 1'b1;
        align;
        rst_b = 1'b0;
        idle(20);

        // Final report.
        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);
        check("a_done_per_frame", a_dones, a_frames);
        check("b_frame_count", b_frames, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
